// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: 8N1 serial receiver; valid/frame_err pulse on the edge that samples the stop bit, no backpressure.
// Define UART_RX_SYNC_EN to put a 2-flop synchronizer on rxd (all timing shifts by 2 cycles).
module uart_rx_fsm #(
   parameter int unsigned CLKS_PER_BIT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);
   localparam logic [15:0] HALF_BIT = 16'((CLKS_PER_BIT - 1) / 2);
   localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] clk_cnt, clk_cnt_nxt;
   logic [2:0]  bit_cnt, bit_cnt_nxt;
   logic [7:0]  shift_reg, shift_nxt;
   logic [7:0]  data_nxt;
   logic        valid_nxt, frame_err_nxt;
   logic        rxd_s;

`ifdef UART_RX_SYNC_EN
   logic sync_q1, sync_q2;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q1 <= 1'b1;
         sync_q2 <= 1'b1;
      end else begin
         sync_q1 <= rxd;
         sync_q2 <= sync_q1;
      end
   end

   assign rxd_s = sync_q2;
`else
   assign rxd_s = rxd;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         clk_cnt   <= 16'd0;
         bit_cnt   <= 3'd0;
         shift_reg <= 8'h00;
         data      <= 8'h00;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         clk_cnt   <= clk_cnt_nxt;
         bit_cnt   <= bit_cnt_nxt;
         shift_reg <= shift_nxt;
         data      <= data_nxt;
         valid     <= valid_nxt;
         frame_err <= frame_err_nxt;
         busy      <= (state_nxt != IDLE);
      end
   end

   always_comb begin
      state_nxt     = state;
      clk_cnt_nxt   = clk_cnt;
      bit_cnt_nxt   = bit_cnt;
      shift_nxt     = shift_reg;
      data_nxt      = data;
      valid_nxt     = 1'b0;
      frame_err_nxt = 1'b0;

      case (state)
         IDLE: begin
            // This cycle is sample 0 of the start bit.
            if (!rxd_s) begin
               if (HALF_BIT == 16'd0) begin
                  state_nxt   = DATA;
                  clk_cnt_nxt = 16'd0;
                  bit_cnt_nxt = 3'd0;
               end else begin
                  state_nxt   = START;
                  clk_cnt_nxt = 16'd1;
               end
            end
         end

         START: begin
            if (clk_cnt == HALF_BIT) begin
               clk_cnt_nxt = 16'd0;
               bit_cnt_nxt = 3'd0;
               state_nxt   = rxd_s ? IDLE : DATA;
            end else begin
               clk_cnt_nxt = clk_cnt + 16'd1;
            end
         end

         DATA: begin
            if (clk_cnt == LAST_CNT) begin
               clk_cnt_nxt = 16'd0;
               shift_nxt   = {rxd_s, shift_reg[7:1]};
               bit_cnt_nxt = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  state_nxt = STOP;
               end
            end else begin
               clk_cnt_nxt = clk_cnt + 16'd1;
            end
         end

         STOP: begin
            if (clk_cnt == LAST_CNT) begin
               clk_cnt_nxt = 16'd0;
               if (rxd_s) begin
                  data_nxt  = shift_reg;
                  valid_nxt = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  frame_err_nxt = 1'b1;
                  state_nxt     = BREAK;
               end
            end else begin
               clk_cnt_nxt = clk_cnt + 16'd1;
            end
         end

         // A held-low line must go high before another start bit is accepted.
         BREAK: begin
            if (rxd_s) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: three instances (CLKS_PER_BIT 1, 16, 4) driven by a bit-level transmitter model.
module tb_uart_rx_fsm;
`ifdef UART_RX_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]      rst_line;
   logic [2:0]      rxd_line;
   logic [2:0][7:0] data_w;
   logic [2:0]      valid_w;
   logic [2:0]      frame_err_w;
   logic [2:0]      busy_w;

   uart_rx_fsm #(.CLKS_PER_BIT(1)) u_cpb1 (
      .clk(clk), .rst(rst_line[0]), .rxd(rxd_line[0]), .data(data_w[0]),
      .valid(valid_w[0]), .frame_err(frame_err_w[0]), .busy(busy_w[0]));
   uart_rx_fsm #(.CLKS_PER_BIT(16)) u_cpb16 (
      .clk(clk), .rst(rst_line[1]), .rxd(rxd_line[1]), .data(data_w[1]),
      .valid(valid_w[1]), .frame_err(frame_err_w[1]), .busy(busy_w[1]));
   uart_rx_fsm #(.CLKS_PER_BIT(4)) u_cpb4 (
      .clk(clk), .rst(rst_line[2]), .rxd(rxd_line[2]), .data(data_w[2]),
      .valid(valid_w[2]), .frame_err(frame_err_w[2]), .busy(busy_w[2]));

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int busy_cnt[3];
   int valid_cnt[3];
   int fe_cnt[3];
   int last_valid_cyc[3];
   int stop_cyc[3];
   logic [7:0] exp_q[3][$];

   // Samples every instance on the falling edge; valid pops the scoreboard.
   task automatic tick();
      logic [7:0] e;
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
         if (busy_w[i] === 1'b1) busy_cnt[i]++;
         if (frame_err_w[i] === 1'b1) fe_cnt[i]++;
         if (valid_w[i] === 1'b1) begin
            valid_cnt[i]++;
            last_valid_cyc[i] = cyc;
            n_checks++;
            if (exp_q[i].size() == 0) begin
               n_fail++;
               $display("FAIL sb_unexpected inst%0d: got valid with data %h, expected no valid", i, data_w[i]);
            end else begin
               e = exp_q[i].pop_front();
               if (data_w[i] !== e) begin
                  n_fail++;
                  $display("FAIL sb_data inst%0d: got %h, expected %h", i, data_w[i], e);
               end
            end
            n_checks++;
            if (frame_err_w[i] !== 1'b0) begin
               n_fail++;
               $display("FAIL valid_fe_overlap inst%0d: frame_err %b with valid, expected 0", i, frame_err_w[i]);
            end
         end
      end
   endtask

   task automatic drive_bits(input int sel, input int cpb, input logic [9:0] frame, input int nbits);
      for (int b = 0; b < nbits; b++) begin
         rxd_line[sel] = frame[b];
         if (b == 9) stop_cyc[sel] = cyc;
         repeat (cpb) tick();
      end
   endtask

   task automatic send_byte(input int sel, input int cpb, input logic [7:0] byte_v);
      exp_q[sel].push_back(byte_v);
      drive_bits(sel, cpb, {1'b1, byte_v, 1'b0}, 10);
   endtask

   task automatic test_reset();
      rst_line = 3'b000;
      rxd_line = 3'b111;
      repeat (3) tick();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (data_w[i] !== 8'h00) begin n_fail++; $display("FAIL reset_data inst%0d: got %h, expected 00", i, data_w[i]); end
         n_checks++;
         if (valid_w[i] !== 1'b0) begin n_fail++; $display("FAIL reset_valid inst%0d: got %b, expected 0", i, valid_w[i]); end
         n_checks++;
         if (frame_err_w[i] !== 1'b0) begin n_fail++; $display("FAIL reset_fe inst%0d: got %b, expected 0", i, frame_err_w[i]); end
         n_checks++;
         if (busy_w[i] !== 1'b0) begin n_fail++; $display("FAIL reset_busy inst%0d: got %b, expected 0", i, busy_w[i]); end
      end
      rst_line = 3'b111;
      repeat (2) tick();
   endtask

   task automatic test_loopback_a5();
      int b0, v0, f0;
      b0 = busy_cnt[0]; v0 = valid_cnt[0]; f0 = fe_cnt[0];
      send_byte(0, 1, 8'hA5);
      repeat (6) tick();
      n_checks++;
      if (valid_cnt[0] - v0 != 1) begin n_fail++; $display("FAIL a5_valid_cycles: got %0d, expected 1", valid_cnt[0] - v0); end
      n_checks++;
      if (fe_cnt[0] - f0 != 0) begin n_fail++; $display("FAIL a5_frame_err: got %0d pulses, expected 0", fe_cnt[0] - f0); end
      // DATA occupies 8 cycles and STOP one at one clock per bit.
      n_checks++;
      if (busy_cnt[0] - b0 != 9) begin n_fail++; $display("FAIL a5_busy_cycles: got %0d, expected 9", busy_cnt[0] - b0); end
      n_checks++;
      if (last_valid_cyc[0] - stop_cyc[0] != 1 + SYNC_LAT) begin
         n_fail++;
         $display("FAIL a5_latency: got %0d, expected %0d", last_valid_cyc[0] - stop_cyc[0], 1 + SYNC_LAT);
      end
      n_checks++;
      if (data_w[0] !== 8'hA5) begin n_fail++; $display("FAIL a5_data_hold: got %h, expected a5", data_w[0]); end
   endtask

   task automatic test_back_to_back();
      int v0, f0;
      v0 = valid_cnt[0]; f0 = fe_cnt[0];
      send_byte(0, 1, 8'h00);
      send_byte(0, 1, 8'hFF);
      send_byte(0, 1, 8'h5A);
      repeat (6) tick();
      n_checks++;
      if (valid_cnt[0] - v0 != 3) begin n_fail++; $display("FAIL b2b_valid_count: got %0d, expected 3", valid_cnt[0] - v0); end
      n_checks++;
      if (fe_cnt[0] - f0 != 0) begin n_fail++; $display("FAIL b2b_frame_err: got %0d, expected 0", fe_cnt[0] - f0); end
      n_checks++;
      if (exp_q[0].size() != 0) begin n_fail++; $display("FAIL b2b_pending: got %0d bytes left, expected 0", exp_q[0].size()); end
   endtask

   task automatic test_start_glitch();
      int b0, v0, f0;
      b0 = busy_cnt[1]; v0 = valid_cnt[1]; f0 = fe_cnt[1];
      rxd_line[1] = 1'b0;
      repeat (3) tick();
      rxd_line[1] = 1'b1;
      repeat (30) tick();
      n_checks++;
      if (busy_cnt[1] - b0 != 7) begin n_fail++; $display("FAIL glitch_busy_cycles: got %0d, expected 7", busy_cnt[1] - b0); end
      n_checks++;
      if (valid_cnt[1] - v0 != 0) begin n_fail++; $display("FAIL glitch_valid: got %0d, expected 0", valid_cnt[1] - v0); end
      n_checks++;
      if (fe_cnt[1] - f0 != 0) begin n_fail++; $display("FAIL glitch_frame_err: got %0d, expected 0", fe_cnt[1] - f0); end
      n_checks++;
      if (busy_w[1] !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: busy %b, expected 0", busy_w[1]); end
   endtask

   task automatic test_break();
      int v0, f0;
      send_byte(1, 16, 8'h69);
      repeat (20) tick();
      v0 = valid_cnt[1]; f0 = fe_cnt[1];
      drive_bits(1, 16, {1'b0, 8'h3C, 1'b0}, 10);
      repeat (40) tick();
      n_checks++;
      if (fe_cnt[1] - f0 != 1) begin n_fail++; $display("FAIL brk_frame_err: got %0d pulses, expected 1", fe_cnt[1] - f0); end
      n_checks++;
      if (busy_w[1] !== 1'b1) begin n_fail++; $display("FAIL brk_held: busy %b while line low, expected 1", busy_w[1]); end
      n_checks++;
      if (data_w[1] !== 8'h69) begin n_fail++; $display("FAIL brk_data_kept: got %h, expected 69", data_w[1]); end
      rxd_line[1] = 1'b1;
      repeat (20) tick();
      n_checks++;
      if (busy_w[1] !== 1'b0) begin n_fail++; $display("FAIL brk_release: busy %b, expected 0", busy_w[1]); end
      n_checks++;
      if (valid_cnt[1] - v0 != 0) begin n_fail++; $display("FAIL brk_valid: got %0d, expected 0", valid_cnt[1] - v0); end
      send_byte(1, 16, 8'hC3);
      repeat (20) tick();
      n_checks++;
      if (valid_cnt[1] - v0 != 1) begin n_fail++; $display("FAIL brk_recover: got %0d valid, expected 1", valid_cnt[1] - v0); end
      n_checks++;
      if (data_w[1] !== 8'hC3) begin n_fail++; $display("FAIL brk_recover_data: got %h, expected c3", data_w[1]); end
   endtask

   task automatic test_reset_mid_frame();
      int v0;
      send_byte(2, 4, 8'h81);
      repeat (10) tick();
      n_checks++;
      if (data_w[2] !== 8'h81) begin n_fail++; $display("FAIL mid_pre_data: got %h, expected 81", data_w[2]); end
      v0 = valid_cnt[2];
      drive_bits(2, 4, {1'b1, 8'h81, 1'b0}, 5);
      rxd_line[2] = 1'b0;
      repeat (2) tick();
      rst_line[2] = 1'b0;
      tick();
      n_checks++;
      if (data_w[2] !== 8'h00) begin n_fail++; $display("FAIL mid_rst_data: got %h, expected 00", data_w[2]); end
      n_checks++;
      if (valid_w[2] !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b, expected 0", valid_w[2]); end
      n_checks++;
      if (frame_err_w[2] !== 1'b0) begin n_fail++; $display("FAIL mid_rst_fe: got %b, expected 0", frame_err_w[2]); end
      n_checks++;
      if (busy_w[2] !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b, expected 0", busy_w[2]); end
      rst_line[2] = 1'b1;
      rxd_line[2] = 1'b1;
      repeat (40) tick();
      n_checks++;
      if (valid_cnt[2] - v0 != 0) begin n_fail++; $display("FAIL mid_no_valid: got %0d, expected 0", valid_cnt[2] - v0); end
      send_byte(2, 4, 8'h81);
      repeat (10) tick();
      n_checks++;
      if (valid_cnt[2] - v0 != 1) begin n_fail++; $display("FAIL mid_next_frame: got %0d valid, expected 1", valid_cnt[2] - v0); end
   endtask

   initial begin
      rst_line = 3'b000;
      rxd_line = 3'b111;
      for (int i = 0; i < 3; i++) begin
         busy_cnt[i] = 0; valid_cnt[i] = 0; fe_cnt[i] = 0;
         last_valid_cyc[i] = 0; stop_cyc[i] = 0;
      end
      test_reset();
      test_loopback_a5();
      test_back_to_back();
      test_start_glitch();
      test_break();
      test_reset_mid_frame();
      repeat (4) tick();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (exp_q[i].size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain inst%0d: got %0d bytes never received, expected 0", i, exp_q[i].size());
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
